decoder3to8_reg: RTL and testbench

- Registered 3-to-8 one-hot decoder.
- The 3-bit select is formed as {en, a, b}; en is the MSB, or bank select: en=0 drives out[3:0], en=1 drives out[7:4].
- Used as a generic address/strobe decoder in the control path. Output is registered to give a clean, glitch-free one-hot strobe bus.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decode_core_3to8.sv | 11 +
 rtl/decoder3to8_reg.sv | 53 +++++
 tb/tb_decoder3to8_reg.sv | 127 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths and decode helpers for the 3-to-8 strobe decoder family.
package decoder_pkg;

   localparam int SEL_W = 3;
   localparam int OUT_W = 8;

   function automatic logic [OUT_W-1:0] onehot8(input logic [SEL_W-1:0] sel);
      logic [OUT_W-1:0] word;
      word      = '0;
      word[sel] = 1'b1;
      return word;
   endfunction

   // Word presented while no line may be asserted (reset).
   function automatic logic [OUT_W-1:0] idle_word(input logic active_low);
      return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
   endfunction

   function automatic logic [OUT_W-1:0] apply_polarity(input logic [OUT_W-1:0] onehot,
                                                       input logic            active_low);
      return active_low ? ~onehot : onehot;
   endfunction

endpackage

// File: rtl/decode_core_3to8.sv
// Purely combinational 3-bit select to 8-bit one-hot decode.
module decode_core_3to8
   import decoder_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] onehot
);

   assign onehot = onehot8(sel);

endmodule

// File: rtl/decoder3to8_reg.sv
// Registered (or optionally combinational) 3-to-8 one-hot strobe decoder.
// en is the bank select (MSB of the index), not a gating enable.
module decoder3to8_reg
   import decoder_pkg::*;
#(
   parameter int OUT_REG        = 1,
   parameter int OUT_ACTIVE_LOW = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   output logic [OUT_W-1:0] out
);

   localparam logic             ACTIVE_LOW = (OUT_ACTIVE_LOW != 0);
   localparam logic [OUT_W-1:0] OUT_IDLE   = idle_word(ACTIVE_LOW);

   logic [SEL_W-1:0] sel_p0;
   logic [OUT_W-1:0] onehot_p0;
   logic [OUT_W-1:0] word_p0;

   // Stage p0: index formation, decode and polarity
   assign sel_p0 = {en, a, b};

   decode_core_3to8 u_core (
      .sel    (sel_p0),
      .onehot (onehot_p0)
   );

   assign word_p0 = apply_polarity(onehot_p0, ACTIVE_LOW);

   // Stage p1: optional output register; reset overrides the decode in both variants
   generate
      if (OUT_REG != 0) begin : g_reg
         logic [OUT_W-1:0] out_p1;

         always_ff @(posedge clk) begin
            if (rst) out_p1 <= OUT_IDLE;
            else     out_p1 <= word_p0;
         end

         assign out = out_p1;
      end else begin : g_comb
         logic unused_clk;
         assign unused_clk = clk;
         assign out        = rst ? OUT_IDLE : word_p0;
      end
   endgenerate

endmodule

// File: tb/tb_decoder3to8_reg.sv
// Scoreboard bench for decoder3to8_reg: four parameter variants driven in parallel,
// expected words produced from a shift-based reference model.
`timescale 1ns/1ps
module tb_decoder3to8_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1, a = 1'b1, b = 1'b1;
   logic [7:0] out_reg_hi, out_reg_lo, out_comb_hi, out_comb_lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q_reg_hi[$], q_reg_lo[$], q_comb_hi[$], q_comb_lo[$];
   logic       q_rst[$];

   always #5 clk = ~clk;

   decoder3to8_reg #(.OUT_REG(1), .OUT_ACTIVE_LOW(0)) dut_reg_hi (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .out(out_reg_hi));
   decoder3to8_reg #(.OUT_REG(1), .OUT_ACTIVE_LOW(1)) dut_reg_lo (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .out(out_reg_lo));
   decoder3to8_reg #(.OUT_REG(0), .OUT_ACTIVE_LOW(0)) dut_comb_hi (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .out(out_comb_hi));
   decoder3to8_reg #(.OUT_REG(0), .OUT_ACTIVE_LOW(1)) dut_comb_lo (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .out(out_comb_lo));

   function automatic logic [7:0] model(input logic r, input logic [2:0] s, input logic low);
      int idx;
      logic [7:0] w;
      idx = 4 * int'(s[2]) + 2 * int'(s[1]) + int'(s[0]);
      w   = r ? 8'h00 : 8'(1 << idx);
      return low ? ~w : w;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] s);
      @(negedge clk);
      rst = r;
      {en, a, b} = s;
      q_reg_hi.push_back(model(r, s, 1'b0));
      q_reg_lo.push_back(model(r, s, 1'b1));
      q_comb_hi.push_back(model(r, s, 1'b0));
      q_comb_lo.push_back(model(r, s, 1'b1));
      q_rst.push_back(r);
   endtask

   // Registered monitor: output after an edge reflects inputs driven before it.
   initial begin
      logic [7:0] e;
      logic       r;
      forever begin
         @(posedge clk);
         #1;
         if (q_reg_hi.size() > 0) begin
            e = q_reg_hi.pop_front();
            r = q_rst.pop_front();
            check("reg_hi", out_reg_hi, e);
            e = q_reg_lo.pop_front();
            check("reg_lo", out_reg_lo, e);
            if (!r) begin
               n_checks++;
               if (!$onehot(out_reg_hi)) begin
                  n_fail++;
                  $display("FAIL onehot: got %02h expected exactly one bit set", out_reg_hi);
               end
            end
         end
      end
   end

   // Combinational monitor: same half-cycle as the input change.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (q_comb_hi.size() > 0) begin
            e = q_comb_hi.pop_front();
            check("comb_hi", out_comb_hi, e);
            e = q_comb_lo.pop_front();
            check("comb_lo", out_comb_lo, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step(1'b1, 3'b111);
      step(1'b1, 3'b111);
      step(1'b0, 3'b111);
      for (int i = 0; i < 8; i++) step(1'b0, 3'(i));
      for (int i = 0; i < 8; i++) step(1'b0, {i[0], 2'b10});
      step(1'b0, 3'b101);
      step(1'b0, 3'b101);
      step(1'b1, 3'b101);
      step(1'b0, 3'b101);
      step(1'b1, 3'b011);
      step(1'b0, 3'b011);
      step(1'b0, 3'b000);
      step(1'b0, 3'b110);
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));
      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if (q_reg_hi.size() != 0 || q_comb_hi.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q_reg_hi.size(), q_comb_hi.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
